// File: rtl/alu_share_ctrl_pkg.sv
// Shared constants and state encoding for the ALU sharing controller.
// Opcode limit, local error codes and arbiter FSM states.
package alu_share_ctrl_pkg;

   localparam logic [7:0] OP_MAX      = 8'd10;
   localparam logic [7:0] ERR_ILLEGAL = 8'hFE;
   localparam logic [7:0] ERR_TIMEOUT = 8'hFF;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_RESP
   } arb_state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping, wins. Returns one-hot grant, its index and an any flag.
module alu_share_ctrl_rr_arbiter #(
   parameter  int N   = 2,
   localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_idx,
   output logic           any
);

   // Scan from ptr upward, modulo N, keeping the first hit.
   always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU among NUM_REQ requesters with round-robin arbitration,
// local illegal-opcode answers and a per-command completion timeout.
module alu_share_ctrl
   import alu_share_ctrl_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   parameter  int TIMEOUT = 64,
   localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [8*NUM_REQ-1:0]  req_op,
   input  logic [NUM_REQ-1:0]    req_sv,
   input  logic [NUM_REQ-1:0]    req_op_prefix,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]    rsp_valid,
   input  logic [NUM_REQ-1:0]    rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [63:0]           rsp_result,
   output logic [7:0]            rsp_err,
   output logic                  rsp_gp,
   output logic                  alu_start,
   output logic [7:0]            alu_op,
   output logic                  alu_sv,
   output logic                  alu_op_prefix,
   output logic [31:0]           alu_a,
   output logic [31:0]           alu_b,
   input  logic                  alu_done,
   input  logic                  alu_gp,
   input  logic [63:0]           alu_result,
   input  logic [7:0]            alu_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   arb_state_t       state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [7:0]       op_q, op_d;
   logic             sv_q, sv_d;
   logic             pfx_q, pfx_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [63:0]      res_q, res_d;
   logic [7:0]       err_q, err_d;
   logic             gp_q, gp_d;

   logic [NUM_REQ-1:0] gnt;
   logic [IDW-1:0]     gnt_idx;
   logic               gnt_any;

   logic [7:0]  sel_op;
   logic        sel_sv;
   logic        sel_pfx;
   logic [31:0] sel_a;
   logic [31:0] sel_b;

   alu_share_ctrl_rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (gnt_any)
   );

   // Select the granted requester's command fields.
   always_comb begin
      sel_op  = '0;
      sel_sv  = 1'b0;
      sel_pfx = 1'b0;
      sel_a   = '0;
      sel_b   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_op  = req_op[8*i +: 8];
            sel_sv  = req_sv[i];
            sel_pfx = req_op_prefix[i];
            sel_a   = req_a[32*i +: 32];
            sel_b   = req_b[32*i +: 32];
         end
      end
   end

   // Next-state logic: accept, issue, wait/timeout, respond.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      timer_d   = timer_q;
      op_d      = op_q;
      sv_d      = sv_q;
      pfx_d     = pfx_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      err_d     = err_q;
      gp_d      = gp_q;
      req_ready = '0;
      unique case (state_q)
         ARB_IDLE: begin
            if (gnt_any) begin
               req_ready = gnt;
               id_d      = gnt_idx;
               ptr_d     = IDW'((int'(gnt_idx) + 1) % NUM_REQ);
               op_d      = sel_op;
               sv_d      = sel_sv;
               pfx_d     = sel_pfx;
               a_d       = sel_a;
               b_d       = sel_b;
               timer_d   = '0;
               if (sel_op > OP_MAX) begin
                  res_d   = '0;
                  err_d   = ERR_ILLEGAL;
                  gp_d    = 1'b0;
                  state_d = ARB_RESP;
               end else begin
                  state_d = ARB_ISSUE;
               end
            end
         end
         ARB_ISSUE: begin
            timer_d = timer_q + 1'b1;
            state_d = ARB_WAIT;
         end
         ARB_WAIT: begin
            if (alu_done) begin
               res_d   = alu_result;
               err_d   = alu_err;
               gp_d    = alu_gp;
               state_d = ARB_RESP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               res_d   = '0;
               err_d   = ERR_TIMEOUT;
               gp_d    = 1'b0;
               state_d = ARB_RESP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ARB_RESP: begin
            if (rsp_ready[id_q]) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // State and datapath registers; reset clears everything at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         timer_q <= '0;
         op_q    <= '0;
         sv_q    <= 1'b0;
         pfx_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         err_q   <= '0;
         gp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         timer_q <= timer_d;
         op_q    <= op_d;
         sv_q    <= sv_d;
         pfx_q   <= pfx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         err_q   <= err_d;
         gp_q    <= gp_d;
      end
   end

   // ALU bus is driven only while a command is in flight.
   always_comb begin
      alu_start     = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT);
      alu_op        = alu_start ? op_q : '0;
      alu_sv        = alu_start & sv_q;
      alu_op_prefix = alu_start & pfx_q;
      alu_a         = alu_start ? a_q : '0;
      alu_b         = alu_start ? b_q : '0;
   end

   // Response channel: one-hot valid toward the owning requester.
   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i] = (state_q == ARB_RESP) && (id_q == IDW'(i));
      end
      rsp_id     = id_q;
      rsp_result = res_q;
      rsp_err    = err_q;
      rsp_gp     = gp_q;
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small behavioural ALU
// that answers after a programmable latency.
module tb_alu_share_ctrl;

   localparam int N = 2;

   logic          clk;
   logic          reset_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [8*N-1:0]  req_op;
   logic [N-1:0]  req_sv;
   logic [N-1:0]  req_op_prefix;
   logic [32*N-1:0] req_a;
   logic [32*N-1:0] req_b;
   logic [N-1:0]  rsp_valid;
   logic [N-1:0]  rsp_ready;
   logic          rsp_id;
   logic [63:0]   rsp_result;
   logic [7:0]    rsp_err;
   logic          rsp_gp;
   logic          alu_start;
   logic [7:0]    alu_op;
   logic          alu_sv;
   logic          alu_op_prefix;
   logic [31:0]   alu_a;
   logic [31:0]   alu_b;
   logic          alu_done;
   logic          alu_gp;
   logic [63:0]   alu_result;
   logic [7:0]    alu_err;

   int checks = 0;
   int errors = 0;

   logic alu_en;
   int   alu_lat;
   logic force_done;
   int   cnt;

   alu_share_ctrl #(.NUM_REQ(N), .TIMEOUT(64)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_sv        (req_sv),
      .req_op_prefix (req_op_prefix),
      .req_a         (req_a),
      .req_b         (req_b),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_result    (rsp_result),
      .rsp_err       (rsp_err),
      .rsp_gp        (rsp_gp),
      .alu_start     (alu_start),
      .alu_op        (alu_op),
      .alu_sv        (alu_sv),
      .alu_op_prefix (alu_op_prefix),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_done      (alu_done),
      .alu_gp        (alu_gp),
      .alu_result    (alu_result),
      .alu_err       (alu_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural ALU: done after alu_lat cycles of start, sum result.
   initial begin
      cnt = 0;
      forever begin
         @(negedge clk);
         if (alu_start) cnt = cnt + 1;
         else cnt = 0;
         alu_done = force_done ||
                    (alu_en && alu_start && cnt == alu_lat);
         if (alu_start) alu_result = {32'd0, alu_a} + {32'd0, alu_b};
         alu_err = force_done ? 8'h5A : 8'h00;
         alu_gp  = alu_done;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      req_op[8*i +: 8]  = op;
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      while (rsp_valid == '0 && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask

   task automatic ack(input int i);
      rsp_ready[i] = 1'b1;
      tick();
      rsp_ready = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({req_ready, rsp_valid, alu_start, alu_op, alu_a, alu_b} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b vld=%b st=%b op=%h",
                  req_ready, rsp_valid, alu_start, alu_op);
      end
      checks++;
      if ({rsp_result, rsp_err, rsp_gp, rsp_id} !== '0) begin
         errors++;
         $display("FAIL reset_rsp got res=%h err=%h", rsp_result, rsp_err);
      end
   endtask

   task automatic test_add();
      int st, cyc;
      set_req(0, 8'd1, 32'd5, 32'd7);
      req_valid = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL add_ready got %b want 01", req_ready);
      end
      tick();
      req_valid = '0;
      checks++;
      if ({alu_start, alu_op, alu_a, alu_b} !== {1'b1, 8'd1, 32'd5, 32'd7}) begin
         errors++;
         $display("FAIL add_issue got st=%b op=%0d a=%0d b=%0d",
                  alu_start, alu_op, alu_a, alu_b);
      end
      st  = 0;
      cyc = 0;
      while (rsp_valid == '0 && cyc < 50) begin
         if (alu_start) st++;
         tick();
         cyc++;
      end
      checks++;
      if (st !== 3 || alu_start !== 1'b0) begin
         errors++;
         $display("FAIL add_start_len got %0d cycles (st=%b) want 3",
                  st, alu_start);
      end
      checks++;
      if ({rsp_valid, rsp_id} !== {2'b01, 1'b0} || rsp_result !== 64'd12 ||
          rsp_err !== 8'd0 || rsp_gp !== 1'b1) begin
         errors++;
         $display("FAIL add_rsp got v=%b id=%b res=%0d err=%h gp=%b want 01/0/12/00/1",
                  rsp_valid, rsp_id, rsp_result, rsp_err, rsp_gp);
      end
      ack(0);
      checks++;
      if (rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL add_rsp_clear got %b want 00", rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [1:0] want;
      do_reset();
      set_req(0, 8'd1, 32'd10, 32'd1);
      set_req(1, 8'd1, 32'd20, 32'd2);
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         want = (k % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         checks++;
         if (req_ready !== want) begin
            errors++;
            $display("FAIL b2b_grant%0d got %b want %b", k, req_ready, want);
         end
         tick();
         wait_rsp(cyc);
         checks++;
         if (rsp_valid !== want ||
             rsp_result !== ((k % 2 == 0) ? 64'd11 : 64'd22)) begin
            errors++;
            $display("FAIL b2b_rsp%0d got v=%b res=%0d", k, rsp_valid, rsp_result);
         end
         rsp_ready = want;
         tick();
         rsp_ready = '0;
         if (k == 3) req_valid = '0;
      end
   endtask

   task automatic test_illegal();
      int cyc;
      set_req(1, 8'd12, 32'd3, 32'd4);
      req_valid = 2'b10;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL ill_ready got %b want 10", req_ready);
      end
      tick();
      req_valid = '0;
      checks++;
      if (alu_start !== 1'b0 || alu_op !== 8'd0) begin
         errors++;
         $display("FAIL ill_no_start got st=%b op=%h", alu_start, alu_op);
      end
      cyc = 0;
      while (rsp_valid == '0 && cyc < 2) begin
         tick();
         cyc++;
      end
      checks++;
      if (rsp_valid !== 2'b10 || rsp_id !== 1'b1 ||
          rsp_err !== 8'hFE || rsp_result !== 64'd0) begin
         errors++;
         $display("FAIL ill_rsp got v=%b id=%b err=%h res=%h want 10/1/fe/0",
                  rsp_valid, rsp_id, rsp_err, rsp_result);
      end
      ack(1);
   endtask

   task automatic test_timeout();
      int cyc;
      alu_en = 1'b0;
      set_req(0, 8'd2, 32'd1, 32'd1);
      req_valid = 2'b01;
      tick();
      req_valid = '0;
      wait_rsp(cyc);
      checks++;
      if (cyc !== 64) begin
         errors++;
         $display("FAIL to_latency got %0d cycles want 64", cyc);
      end
      checks++;
      if (rsp_valid !== 2'b01 || rsp_err !== 8'hFF || rsp_result !== 64'd0 ||
          rsp_gp !== 1'b0 || alu_start !== 1'b0) begin
         errors++;
         $display("FAIL to_rsp got v=%b err=%h res=%h gp=%b st=%b",
                  rsp_valid, rsp_err, rsp_result, rsp_gp, alu_start);
      end
      force_done = 1'b1;
      tick();
      tick();
      force_done = 1'b0;
      checks++;
      if (rsp_err !== 8'hFF || rsp_valid !== 2'b01) begin
         errors++;
         $display("FAIL to_late_done got err=%h v=%b want ff/01", rsp_err, rsp_valid);
      end
      ack(0);
      alu_en  = 1'b1;
      alu_lat = 2;
      set_req(1, 8'd1, 32'd3, 32'd4);
      req_valid = 2'b10;
      tick();
      req_valid = '0;
      wait_rsp(cyc);
      checks++;
      if (rsp_valid !== 2'b10 || rsp_result !== 64'd7 || rsp_err !== 8'd0) begin
         errors++;
         $display("FAIL to_next_cmd got v=%b res=%0d err=%h want 10/7/00",
                  rsp_valid, rsp_result, rsp_err);
      end
      ack(1);
   endtask

   task automatic test_backpressure();
      int cyc;
      set_req(0, 8'd1, 32'd100, 32'd23);
      req_valid = 2'b01;
      tick();
      set_req(1, 8'd1, 32'd1, 32'd1);
      req_valid = 2'b10;
      wait_rsp(cyc);
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (rsp_valid !== 2'b01 || rsp_result !== 64'd123 ||
             rsp_err !== 8'd0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_hold%0d got v=%b res=%0d rdy=%b",
                     k, rsp_valid, rsp_result, req_ready);
         end
         tick();
      end
      ack(0);
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL bp_next_accept got %b want 10", req_ready);
      end
      tick();
      req_valid = '0;
      wait_rsp(cyc);
      checks++;
      if (rsp_valid !== 2'b10 || rsp_result !== 64'd2) begin
         errors++;
         $display("FAIL bp_next_rsp got v=%b res=%0d", rsp_valid, rsp_result);
      end
      ack(1);
   endtask

   task automatic test_reset_mid();
      int cyc;
      alu_en = 1'b0;
      set_req(0, 8'd1, 32'd9, 32'd9);
      req_valid = 2'b01;
      tick();
      req_valid = '0;
      repeat (3) tick();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, alu_start, alu_op, alu_a, alu_b} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs got st=%b a=%0d vld=%b",
                  alu_start, alu_a, rsp_valid);
      end
      tick();
      reset_n = 1'b1;
      alu_en  = 1'b1;
      alu_lat = 2;
      set_req(0, 8'd1, 32'd2, 32'd2);
      set_req(1, 8'd1, 32'd8, 32'd8);
      req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rst_mid_ptr got %b want 01", req_ready);
      end
      tick();
      req_valid = '0;
      wait_rsp(cyc);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_result !== 64'd4) begin
         errors++;
         $display("FAIL rst_mid_rsp got v=%b res=%0d want 01/4", rsp_valid, rsp_result);
      end
      ack(0);
   endtask

   initial begin
      reset_n       = 1'b0;
      req_valid     = '0;
      req_op        = '0;
      req_sv        = '0;
      req_op_prefix = '0;
      req_a         = '0;
      req_b         = '0;
      rsp_ready     = '0;
      alu_done      = 1'b0;
      alu_gp        = 1'b0;
      alu_result    = '0;
      alu_err       = '0;
      alu_en        = 1'b1;
      alu_lat       = 3;
      force_done    = 1'b0;
      test_reset();
      test_add();
      alu_lat = 2;
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
